memory_hs: RTL and testbench

// - Next-generation unified instruction/data memory with two slave ports: IMEM (read-only) and DMEM (read/write, byte strobes).
// - Each port uses a valid/ready request channel and a valid/ready response channel.
// - Each port supports a parametrised number of wait states, address range checking and an error response.
// - Sits between the core's fetch/LSU bus masters and the shared word array.

---
 rtl/memory_hs.sv | 265 ++++++++++++++++++++++++++
 tb/tb_memory_hs.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_hs.sv
// memory_hs: unified instruction/data memory with two independent slave ports.
//
// The word array is shared by both ports:
//   IMEM : read-only port, valid/ready request + valid/ready response
//   DMEM : read/write port with byte strobes, valid/ready request + response
// Each port runs its own small FSM (IDLE / WAIT / RESP). The access itself
// happens on a single clock edge: either the accept edge when NUM_WAIT == 0,
// or the edge on which the wait counter has reached zero.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem_req_valid/ready/addr    IMEM request channel
//   imem_rsp_valid/ready/rdata/err  IMEM response channel
//   dmem_req_valid/ready/addr/wen/wstrb/wdata  DMEM request channel
//   dmem_rsp_valid/ready/rdata/err  DMEM response channel (rdata = 0 on writes)
//
// Out-of-range or misaligned requests are flagged at accept and answered with
// err=1, rdata=0 and no array write, with unchanged latency.
//
// Optional feature macro: MEM_FWD_EN
//   defined   : an IMEM read of the word DMEM writes on the same edge returns
//               the merged (post-write) word.
//   undefined : the IMEM read sees the pre-write word; no forwarding mux.
module memory_hs #(
    parameter int              XLEN       = 32,
    parameter int              MEM_SIZE   = 16384,
    parameter int              ADDR_SHIFT = 2,
    parameter logic [XLEN-1:0] ADDR_BASE  = '0,
    parameter int              NUM_WAIT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_req_valid,
    output logic                 imem_req_ready,
    input  logic [XLEN-1:0]      imem_req_addr,
    output logic                 imem_rsp_valid,
    input  logic                 imem_rsp_ready,
    output logic [XLEN-1:0]      imem_rsp_rdata,
    output logic                 imem_rsp_err,
    input  logic                 dmem_req_valid,
    output logic                 dmem_req_ready,
    input  logic [XLEN-1:0]      dmem_req_addr,
    input  logic                 dmem_req_wen,
    input  logic [XLEN/8-1:0]    dmem_req_wstrb,
    input  logic [XLEN-1:0]      dmem_req_wdata,
    output logic                 dmem_rsp_valid,
    input  logic                 dmem_rsp_ready,
    output logic [XLEN-1:0]      dmem_rsp_rdata,
    output logic                 dmem_rsp_err
);

    localparam int              AW        = $clog2(MEM_SIZE);
    localparam int              NB        = XLEN / 8;
    localparam logic [XLEN:0]   MEM_BYTES = (XLEN+1)'(MEM_SIZE) << ADDR_SHIFT;
    localparam logic [3:0]      WAIT_LOAD = (NUM_WAIT > 0) ? 4'(NUM_WAIT - 1) : 4'd0;
    localparam bit              NO_WAIT   = (NUM_WAIT == 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Range/alignment check; done in XLEN+1 bits so the upper bound cannot wrap.
    function automatic logic addr_err(input logic [XLEN-1:0] a);
        logic [XLEN:0] off;
        off = {1'b0, a} - {1'b0, ADDR_BASE};
        return (a < ADDR_BASE) || (off >= MEM_BYTES) || (a[ADDR_SHIFT-1:0] != '0);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [XLEN-1:0] a);
        return AW'((a - ADDR_BASE) >> ADDR_SHIFT);
    endfunction

    // Byte-strobed merge: each strobe bit selects one byte of the new data.
    function automatic logic [XLEN-1:0] merge_word(input logic [XLEN-1:0] old_w,
                                                   input logic [XLEN-1:0] new_w,
                                                   input logic [NB-1:0]   strb);
        logic [XLEN-1:0] mask;
        for (int b = 0; b < NB; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    logic [XLEN-1:0] mem [MEM_SIZE];

    // ---------------- IMEM port ----------------
    logic [1:0]      imem_state_q, imem_state_d;
    logic [3:0]      imem_cnt_q,   imem_cnt_d;
    logic [AW-1:0]   imem_idx_q,   imem_idx_d;
    logic            imem_err_q,   imem_err_d;
    logic [XLEN-1:0] imem_rdata_q, imem_rdata_d;
    logic            imem_rerr_q,  imem_rerr_d;
    logic            imem_acc, imem_in_wait, imem_do_access, imem_acc_err;
    logic [AW-1:0]   imem_acc_idx;
    logic [XLEN-1:0] imem_rd_word;

    // ---------------- DMEM port ----------------
    logic [1:0]      dmem_state_q, dmem_state_d;
    logic [3:0]      dmem_cnt_q,   dmem_cnt_d;
    logic [AW-1:0]   dmem_idx_q,   dmem_idx_d;
    logic            dmem_err_q,   dmem_err_d;
    logic            dmem_wen_q,   dmem_wen_d;
    logic [NB-1:0]   dmem_wstrb_q, dmem_wstrb_d;
    logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [XLEN-1:0] dmem_rdata_q, dmem_rdata_d;
    logic            dmem_rerr_q,  dmem_rerr_d;
    logic            dmem_acc, dmem_in_wait, dmem_do_access, dmem_acc_err, dmem_acc_wen;
    logic            dmem_do_write;
    logic [AW-1:0]   dmem_acc_idx;
    logic [NB-1:0]   dmem_acc_wstrb;
    logic [XLEN-1:0] dmem_acc_wdata;

    // In RESP the port can take a new request in the same cycle its response
    // is consumed, which gives one transfer per cycle with no wait states.
    assign imem_req_ready = (imem_state_q == ST_IDLE) ||
                            ((imem_state_q == ST_RESP) && imem_rsp_ready);
    assign dmem_req_ready = (dmem_state_q == ST_IDLE) ||
                            ((dmem_state_q == ST_RESP) && dmem_rsp_ready);

    assign imem_acc     = imem_req_valid && imem_req_ready;
    assign dmem_acc     = dmem_req_valid && dmem_req_ready;
    assign imem_in_wait = (imem_state_q == ST_WAIT);
    assign dmem_in_wait = (dmem_state_q == ST_WAIT);

    // Access edge: straight from the request bus when there are no wait
    // states, otherwise from the latched request once the counter expires.
    assign imem_do_access = (imem_acc && NO_WAIT) || (imem_in_wait && (imem_cnt_q == 4'd0));
    assign dmem_do_access = (dmem_acc && NO_WAIT) || (dmem_in_wait && (dmem_cnt_q == 4'd0));

    assign imem_acc_idx   = imem_in_wait ? imem_idx_q   : word_idx(imem_req_addr);
    assign imem_acc_err   = imem_in_wait ? imem_err_q   : addr_err(imem_req_addr);
    assign dmem_acc_idx   = dmem_in_wait ? dmem_idx_q   : word_idx(dmem_req_addr);
    assign dmem_acc_err   = dmem_in_wait ? dmem_err_q   : addr_err(dmem_req_addr);
    assign dmem_acc_wen   = dmem_in_wait ? dmem_wen_q   : dmem_req_wen;
    assign dmem_acc_wstrb = dmem_in_wait ? dmem_wstrb_q : dmem_req_wstrb;
    assign dmem_acc_wdata = dmem_in_wait ? dmem_wdata_q : dmem_req_wdata;

    // rst_n gate keeps a request presented during reset from reaching the array.
    assign dmem_do_write = dmem_do_access && dmem_acc_wen && !dmem_acc_err && rst_n;

`ifdef MEM_FWD_EN
    assign imem_rd_word = (dmem_do_write && (dmem_acc_idx == imem_acc_idx)) ?
                          merge_word(mem[imem_acc_idx], dmem_acc_wdata, dmem_acc_wstrb) :
                          mem[imem_acc_idx];
`else
    assign imem_rd_word = mem[imem_acc_idx];
`endif

    always_comb begin
        imem_state_d = imem_state_q;
        imem_cnt_d   = imem_cnt_q;
        imem_idx_d   = imem_idx_q;
        imem_err_d   = imem_err_q;
        imem_rdata_d = imem_rdata_q;
        imem_rerr_d  = imem_rerr_q;
        case (imem_state_q)
            ST_WAIT: begin
                if (imem_cnt_q == 4'd0) imem_state_d = ST_RESP;
                else                    imem_cnt_d   = imem_cnt_q - 4'd1;
            end
            ST_RESP: if (imem_rsp_ready) imem_state_d = ST_IDLE;
            default: ;
        endcase
        // A new accept overrides the RESP->IDLE return.
        if (imem_acc) begin
            imem_idx_d = word_idx(imem_req_addr);
            imem_err_d = addr_err(imem_req_addr);
            if (NO_WAIT) begin
                imem_state_d = ST_RESP;
            end else begin
                imem_state_d = ST_WAIT;
                imem_cnt_d   = WAIT_LOAD;
            end
        end
        if (imem_do_access) begin
            imem_rerr_d  = imem_acc_err;
            imem_rdata_d = imem_acc_err ? '0 : imem_rd_word;
        end
    end

    always_comb begin
        dmem_state_d = dmem_state_q;
        dmem_cnt_d   = dmem_cnt_q;
        dmem_idx_d   = dmem_idx_q;
        dmem_err_d   = dmem_err_q;
        dmem_wen_d   = dmem_wen_q;
        dmem_wstrb_d = dmem_wstrb_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_rdata_d = dmem_rdata_q;
        dmem_rerr_d  = dmem_rerr_q;
        case (dmem_state_q)
            ST_WAIT: begin
                if (dmem_cnt_q == 4'd0) dmem_state_d = ST_RESP;
                else                    dmem_cnt_d   = dmem_cnt_q - 4'd1;
            end
            ST_RESP: if (dmem_rsp_ready) dmem_state_d = ST_IDLE;
            default: ;
        endcase
        if (dmem_acc) begin
            dmem_idx_d   = word_idx(dmem_req_addr);
            dmem_err_d   = addr_err(dmem_req_addr);
            dmem_wen_d   = dmem_req_wen;
            dmem_wstrb_d = dmem_req_wstrb;
            dmem_wdata_d = dmem_req_wdata;
            if (NO_WAIT) begin
                dmem_state_d = ST_RESP;
            end else begin
                dmem_state_d = ST_WAIT;
                dmem_cnt_d   = WAIT_LOAD;
            end
        end
        if (dmem_do_access) begin
            dmem_rerr_d  = dmem_acc_err;
            dmem_rdata_d = (dmem_acc_err || dmem_acc_wen) ? '0 : mem[dmem_acc_idx];
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_state_q <= ST_IDLE;
            imem_cnt_q   <= '0;
            imem_rdata_q <= '0;
            imem_rerr_q  <= 1'b0;
            dmem_state_q <= ST_IDLE;
            dmem_cnt_q   <= '0;
            dmem_rdata_q <= '0;
            dmem_rerr_q  <= 1'b0;
        end else begin
            imem_state_q <= imem_state_d;
            imem_cnt_q   <= imem_cnt_d;
            imem_rdata_q <= imem_rdata_d;
            imem_rerr_q  <= imem_rerr_d;
            dmem_state_q <= dmem_state_d;
            dmem_cnt_q   <= dmem_cnt_d;
            dmem_rdata_q <= dmem_rdata_d;
            dmem_rerr_q  <= dmem_rerr_d;
        end
    end

    // Latched request fields: only consumed in WAIT, which always follows an accept.
    always_ff @(posedge clk) begin
        imem_idx_q   <= imem_idx_d;
        imem_err_q   <= imem_err_d;
        dmem_idx_q   <= dmem_idx_d;
        dmem_err_q   <= dmem_err_d;
        dmem_wen_q   <= dmem_wen_d;
        dmem_wstrb_q <= dmem_wstrb_d;
        dmem_wdata_q <= dmem_wdata_d;
    end

    always_ff @(posedge clk) begin
        if (dmem_do_write) begin
            mem[dmem_acc_idx] <= merge_word(mem[dmem_acc_idx], dmem_acc_wdata, dmem_acc_wstrb);
        end
    end

    assign imem_rsp_valid = (imem_state_q == ST_RESP);
    assign imem_rsp_rdata = imem_rdata_q;
    assign imem_rsp_err   = imem_rerr_q;
    assign dmem_rsp_valid = (dmem_state_q == ST_RESP);
    assign dmem_rsp_rdata = dmem_rdata_q;
    assign dmem_rsp_err   = dmem_rerr_q;

endmodule

// File: tb/tb_memory_hs.sv
// Bench for memory_hs: instance 0 has NUM_WAIT=0, instance 1 has NUM_WAIT=3.
// Expected values come from a word-level model (associative array) and the
// address rules of the memory map.
module tb_memory_hs;

    localparam int     MEM_SIZE = 16384;
    localparam longint BASE     = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]       i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
    logic [1:0][31:0] i_req_addr, i_rsp_rdata;
    logic [1:0]       d_req_valid, d_req_ready, d_req_wen, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [1:0][3:0]  d_req_wstrb;
    logic [1:0][31:0] d_req_addr, d_req_wdata, d_rsp_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [int];

    memory_hs #(.NUM_WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(i_req_valid[0]), .imem_req_ready(i_req_ready[0]), .imem_req_addr(i_req_addr[0]),
        .imem_rsp_valid(i_rsp_valid[0]), .imem_rsp_ready(i_rsp_ready[0]),
        .imem_rsp_rdata(i_rsp_rdata[0]), .imem_rsp_err(i_rsp_err[0]),
        .dmem_req_valid(d_req_valid[0]), .dmem_req_ready(d_req_ready[0]), .dmem_req_addr(d_req_addr[0]),
        .dmem_req_wen(d_req_wen[0]), .dmem_req_wstrb(d_req_wstrb[0]), .dmem_req_wdata(d_req_wdata[0]),
        .dmem_rsp_valid(d_rsp_valid[0]), .dmem_rsp_ready(d_rsp_ready[0]),
        .dmem_rsp_rdata(d_rsp_rdata[0]), .dmem_rsp_err(d_rsp_err[0])
    );

    memory_hs #(.NUM_WAIT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(i_req_valid[1]), .imem_req_ready(i_req_ready[1]), .imem_req_addr(i_req_addr[1]),
        .imem_rsp_valid(i_rsp_valid[1]), .imem_rsp_ready(i_rsp_ready[1]),
        .imem_rsp_rdata(i_rsp_rdata[1]), .imem_rsp_err(i_rsp_err[1]),
        .dmem_req_valid(d_req_valid[1]), .dmem_req_ready(d_req_ready[1]), .dmem_req_addr(d_req_addr[1]),
        .dmem_req_wen(d_req_wen[1]), .dmem_req_wstrb(d_req_wstrb[1]), .dmem_req_wdata(d_req_wdata[1]),
        .dmem_rsp_valid(d_rsp_valid[1]), .dmem_rsp_ready(d_rsp_ready[1]),
        .dmem_rsp_rdata(d_rsp_rdata[1]), .dmem_rsp_err(d_rsp_err[1])
    );

    // ---------------- reference model ----------------
    function automatic int mkey(input int inst, input logic [31:0] addr);
        return inst * 32'h0010_0000 + int'(addr >> 2);
    endfunction

    function automatic bit exp_err(input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        return (a < BASE) || (a >= BASE + longint'(MEM_SIZE) * 4) || (a % 4 != 0);
    endfunction

    function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic int exp_lat(input int inst);
        return (inst == 0) ? 1 : 4;
    endfunction

    // ---------------- stimulus drivers ----------------
    // One complete transaction; lat counts negedges from the accept edge to rsp_valid.
    task automatic xfer(input int inst, input bit port, input logic [31:0] addr, input bit wen,
                        input logic [3:0] strb, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        if (port) begin
            d_req_valid[inst] = 1'b1; d_req_addr[inst] = addr; d_req_wen[inst] = wen;
            d_req_wstrb[inst] = strb; d_req_wdata[inst] = wdata; d_rsp_ready[inst] = 1'b1;
        end else begin
            i_req_valid[inst] = 1'b1; i_req_addr[inst] = addr; i_rsp_ready[inst] = 1'b1;
        end
        n = 0;
        while (!(port ? d_req_ready[inst] : i_req_ready[inst]) && n < 50) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        if (port) d_req_valid[inst] = 1'b0; else i_req_valid[inst] = 1'b0;
        lat = 1;
        while (!(port ? d_rsp_valid[inst] : i_rsp_valid[inst]) && lat < 50) begin
            @(negedge clk); lat++;
        end
        if (lat >= 50 || n >= 50) lat = -1;
        rdata = port ? d_rsp_rdata[inst] : i_rsp_rdata[inst];
        err   = port ? d_rsp_err[inst]   : i_rsp_err[inst];
    endtask

    task automatic preload(input int inst, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd; logic er; int lat;
        xfer(inst, 1'b1, addr, 1'b1, 4'hF, data, rd, er, lat);
        mdl[mkey(inst, addr)] = data;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            checks++; if (i_rsp_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_i_rsp_valid%0d got %b want 0", k, i_rsp_valid[k]); end
            checks++; if (i_rsp_rdata[k] !== 32'h0) begin errors++; $display("FAIL reset_i_rsp_rdata%0d got %h want 0", k, i_rsp_rdata[k]); end
            checks++; if (i_rsp_err[k] !== 1'b0) begin errors++; $display("FAIL reset_i_rsp_err%0d got %b want 0", k, i_rsp_err[k]); end
            checks++; if (i_req_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_i_req_ready%0d got %b want 1", k, i_req_ready[k]); end
            checks++; if (d_rsp_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_d_rsp_valid%0d got %b want 0", k, d_rsp_valid[k]); end
            checks++; if (d_rsp_rdata[k] !== 32'h0) begin errors++; $display("FAIL reset_d_rsp_rdata%0d got %h want 0", k, d_rsp_rdata[k]); end
            checks++; if (d_rsp_err[k] !== 1'b0) begin errors++; $display("FAIL reset_d_rsp_err%0d got %b want 0", k, d_rsp_err[k]); end
            checks++; if (d_req_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_d_req_ready%0d got %b want 1", k, d_req_ready[k]); end
        end
    endtask

    task automatic test_basic;
        logic [31:0] rd; logic er; int lat;
        xfer(0, 1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, rd, er, lat);
        mdl[mkey(0, 32'h10)] = 32'hDEADBEEF;
        checks++; if (lat !== 1) begin errors++; $display("FAIL basic_wr_lat got %0d want 1", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL basic_wr_rsp got err=%b rdata=%h want err=0 rdata=0", er, rd); end
        xfer(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0, rd, er, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL basic_rd_lat got %0d want 1", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL basic_rd got %h/%b want deadbeef/0", rd, er); end
    endtask

    task automatic test_strobes;
        logic [31:0] rd; logic er; int lat;
        preload(0, 32'h20, 32'h11223344);
        xfer(0, 1'b1, 32'h20, 1'b1, 4'b0101, 32'hAABBCCDD, rd, er, lat);
        mdl[mkey(0, 32'h20)] = merge_ref(mdl[mkey(0, 32'h20)], 32'hAABBCCDD, 4'b0101);
        xfer(0, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge got %h want 11bb33dd", rd); end
        checks++; if (rd !== mdl[mkey(0, 32'h20)]) begin errors++; $display("FAIL strobe_model got %h want %h", rd, mdl[mkey(0, 32'h20)]); end
        // zero-strobe write completes normally and leaves the word alone
        xfer(0, 1'b1, 32'h20, 1'b1, 4'h0, 32'hFFFFFFFF, rd, er, lat);
        checks++; if (er !== 1'b0 || lat !== 1) begin errors++; $display("FAIL strobe_zero_rsp got err=%b lat=%0d want 0/1", er, lat); end
        xfer(1, 1'b0, 32'h20, 1'b0, 4'h0, 32'h0, rd, er, lat);
        xfer(0, 1'b0, 32'h20, 1'b0, 4'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_zero_keep got %h want 11bb33dd", rd); end
    endtask

    task automatic test_wait;
        logic [31:0] rd; logic er; int lat; logic [31:0] v;
        v = $urandom;
        xfer(1, 1'b1, 32'h30, 1'b1, 4'hF, v, rd, er, lat);
        mdl[mkey(1, 32'h30)] = v;
        checks++; if (lat !== 4) begin errors++; $display("FAIL wait_wr_lat got %0d want 4", lat); end
        @(negedge clk);
        i_req_valid[1] = 1'b1; i_req_addr[1] = 32'h30; i_rsp_ready[1] = 1'b0;
        @(negedge clk);
        i_req_valid[1] = 1'b0;
        lat = 1;
        while (!i_rsp_valid[1] && lat < 50) begin @(negedge clk); lat++; end
        checks++; if (lat !== 4) begin errors++; $display("FAIL wait_rd_lat got %0d want 4", lat); end
        i_req_valid[1] = 1'b1; i_req_addr[1] = 32'h34;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (i_rsp_valid[1] !== 1'b1 || i_rsp_rdata[1] !== v || i_rsp_err[1] !== 1'b0 || i_req_ready[1] !== 1'b0) begin
                errors++; $display("FAIL wait_hold%0d got v=%b d=%h e=%b rdy=%b want 1/%h/0/0", c, i_rsp_valid[1], i_rsp_rdata[1], i_rsp_err[1], i_req_ready[1], v);
            end
        end
        i_req_valid[1] = 1'b0; i_rsp_ready[1] = 1'b1;
        @(negedge clk);
        checks++; if (i_rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL wait_release got %b want 0", i_rsp_valid[1]); end
    endtask

    task automatic test_error;
        logic [31:0] rd; logic er; int lat;
        xfer(0, 1'b1, 32'(MEM_SIZE * 4), 1'b0, 4'h0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin errors++; $display("FAIL err_range got err=%b rdata=%h lat=%0d want 1/0/1", er, rd, lat); end
        xfer(0, 1'b1, 32'h13, 1'b1, 4'hF, 32'hCAFEF00D, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_misalign got err=%b rdata=%h want 1/0", er, rd); end
        xfer(0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== mdl[mkey(0, 32'h10)] || er !== 1'b0) begin errors++; $display("FAIL err_no_write got %h want %h", rd, mdl[mkey(0, 32'h10)]); end
        xfer(1, 1'b0, 32'h2, 1'b0, 4'h0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 4) begin errors++; $display("FAIL err_imem_wait got err=%b rdata=%h lat=%0d want 1/0/4", er, rd, lat); end
        preload(0, 32'(MEM_SIZE * 4 - 4), 32'h5A5A1234);
        xfer(0, 1'b0, 32'(MEM_SIZE * 4 - 4), 1'b0, 4'h0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h5A5A1234) begin errors++; $display("FAIL err_last_word got err=%b rdata=%h want 0/5a5a1234", er, rd); end
    endtask

    task automatic test_collision;
        logic [31:0] exp_i;
        preload(0, 32'h40, 32'h0);
        @(negedge clk);
        d_req_valid[0] = 1'b1; d_req_addr[0] = 32'h40; d_req_wen[0] = 1'b1;
        d_req_wstrb[0] = 4'hF; d_req_wdata[0] = 32'h12345678;
        i_req_valid[0] = 1'b1; i_req_addr[0] = 32'h40;
        @(negedge clk);
        d_req_valid[0] = 1'b0; i_req_valid[0] = 1'b0;
`ifdef MEM_FWD_EN
        exp_i = merge_ref(mdl[mkey(0, 32'h40)], 32'h12345678, 4'hF);
`else
        exp_i = mdl[mkey(0, 32'h40)];
`endif
        mdl[mkey(0, 32'h40)] = merge_ref(mdl[mkey(0, 32'h40)], 32'h12345678, 4'hF);
        checks++; if (i_rsp_valid[0] !== 1'b1 || i_rsp_rdata[0] !== exp_i) begin errors++; $display("FAIL collide_imem got v=%b d=%h want 1/%h", i_rsp_valid[0], i_rsp_rdata[0], exp_i); end
        // both ports reading the same word on the same edge
        @(negedge clk);
        d_req_valid[0] = 1'b1; d_req_addr[0] = 32'h40; d_req_wen[0] = 1'b0;
        i_req_valid[0] = 1'b1; i_req_addr[0] = 32'h40;
        @(negedge clk);
        d_req_valid[0] = 1'b0; i_req_valid[0] = 1'b0;
        checks++; if (i_rsp_rdata[0] !== mdl[mkey(0, 32'h40)] || d_rsp_rdata[0] !== mdl[mkey(0, 32'h40)]) begin
            errors++; $display("FAIL dual_read got i=%h d=%h want %h", i_rsp_rdata[0], d_rsp_rdata[0], mdl[mkey(0, 32'h40)]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [8];
        int seen;
        for (int k = 0; k < 8; k++) begin
            addrs[k] = 32'h200 + 32'(4 * k);
            preload(0, addrs[k], $urandom);
        end
        seen = 0;
        @(negedge clk);
        i_rsp_ready[0] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                checks++;
                if (i_rsp_valid[0] !== 1'b1 || i_rsp_rdata[0] !== mdl[mkey(0, addrs[k-1])]) begin
                    errors++; $display("FAIL b2b_%0d got v=%b d=%h want 1/%h", k - 1, i_rsp_valid[0], i_rsp_rdata[0], mdl[mkey(0, addrs[k-1])]);
                end else seen++;
            end
            if (k < 8) begin
                i_req_valid[0] = 1'b1; i_req_addr[0] = addrs[k];
            end else i_req_valid[0] = 1'b0;
            @(negedge clk);
        end
        checks++; if (seen !== 8 || i_rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL b2b_count got %0d tail=%b want 8/0", seen, i_rsp_valid[0]); end
    endtask

    task automatic test_random;
        logic [31:0] rd, addr, wd, e_rd; logic er, e_err; int lat; bit port, wen; logic [3:0] strb; int r;
        for (int inst = 0; inst < 2; inst++) begin
            for (int k = 0; k < 16; k++) preload(inst, 32'h100 + 32'(4 * k), $urandom);
            for (int op = 0; op < 40; op++) begin
                r    = int'($urandom_range(0, 9));
                addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
                if (r == 0) addr = addr + 32'($urandom_range(1, 3));
                if (r == 1) addr = 32'(MEM_SIZE * 4) + 32'(4 * $urandom_range(0, 3));
                port = ($urandom_range(0, 2) != 0);
                wen  = port && ($urandom_range(0, 1) == 1);
                strb = 4'($urandom_range(0, 15));
                wd   = $urandom;
                e_err = exp_err(addr);
                e_rd  = (e_err || wen) ? 32'h0 : mdl[mkey(inst, addr)];
                if (wen && !e_err) mdl[mkey(inst, addr)] = merge_ref(mdl[mkey(inst, addr)], wd, strb);
                xfer(inst, port, addr, wen, strb, wd, rd, er, lat);
                checks++; if (er !== e_err) begin errors++; $display("FAIL rnd_err i%0d op%0d got %b want %b", inst, op, er, e_err); end
                checks++; if (rd !== e_rd) begin errors++; $display("FAIL rnd_rdata i%0d op%0d got %h want %h", inst, op, rd, e_rd); end
                checks++; if (lat !== exp_lat(inst)) begin errors++; $display("FAIL rnd_lat i%0d op%0d got %0d want %0d", inst, op, lat, exp_lat(inst)); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat;
        preload(1, 32'h80, 32'h0BADF00D);
        preload(0, 32'h84, 32'h76543210);
        @(negedge clk);
        i_req_valid[0] = 1'b1; i_req_addr[0] = 32'h84; i_rsp_ready[0] = 1'b0;
        d_req_valid[1] = 1'b1; d_req_addr[1] = 32'h80; d_req_wen[1] = 1'b1;
        d_req_wstrb[1] = 4'hF; d_req_wdata[1] = 32'hFFFF0000; d_rsp_ready[1] = 1'b1;
        @(negedge clk);
        i_req_valid[0] = 1'b0; d_req_valid[1] = 1'b0;
        checks++; if (i_rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b want 1", i_rsp_valid[0]); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (i_rsp_valid !== 2'b00 || d_rsp_valid !== 2'b00) begin errors++; $display("FAIL rstmid_async got i=%b d=%b want 00/00", i_rsp_valid, d_rsp_valid); end
        checks++; if (i_rsp_rdata[0] !== 32'h0 || d_req_ready[1] !== 1'b1) begin errors++; $display("FAIL rstmid_state got d=%h rdy=%b want 0/1", i_rsp_rdata[0], d_req_ready[1]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        i_rsp_ready[0] = 1'b1;
        xfer(1, 1'b1, 32'h80, 1'b0, 4'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== mdl[mkey(1, 32'h80)] || er !== 1'b0) begin errors++; $display("FAIL rstmid_discard got %h want %h", rd, mdl[mkey(1, 32'h80)]); end
        xfer(0, 1'b0, 32'h84, 1'b0, 4'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== mdl[mkey(0, 32'h84)]) begin errors++; $display("FAIL rstmid_persist got %h want %h", rd, mdl[mkey(0, 32'h84)]); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i_req_valid = '0; i_req_addr = '0; i_rsp_ready = 2'b11;
        d_req_valid = '0; d_req_addr = '0; d_req_wen = '0; d_req_wstrb = '0; d_req_wdata = '0;
        d_rsp_ready = 2'b11;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_basic;
        test_strobes;
        test_wait;
        test_error;
        test_collision;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
